// File: rtl/ysyx_23060229_axi_pkg.sv
// Shared constants and state encoding for the AXI4 read-channel responder.
package ysyx_23060229_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  // A request we cannot serve properly: not 32-bit beats, or WRAP/reserved burst.
  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
  endfunction

endpackage

// File: rtl/ysyx_23060229_rd_mem.sv
// Word-addressed backing store for the read responder; combinational read.
module ysyx_23060229_rd_mem #(
  parameter int    DEPTH_LOG2 = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic [DEPTH_LOG2-1:0] idx,
  output logic [31:0]           data
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Asynchronous read; the controller registers the result into rdata.
  assign data = mem[idx];

endmodule

// File: rtl/ysyx_23060229_axi_rd_slave.sv
// AXI4 read responder: one outstanding burst, FIXED/INCR, fixed AR-to-R latency.
// Optional build macro YSYX_23060229_RD_RANGE_ERR_EN flags beats whose address
// falls outside [BASE_ADDR, BASE_ADDR+4*DEPTH) with SLVERR instead of aliasing.
//
// state | meaning
// IDLE  | arready high, waiting for an AR handshake
// WAIT  | request captured, latency counter running down
// BURST | rvalid high, one beat presented per R handshake until rlast
module ysyx_23060229_axi_rd_slave
  import ysyx_23060229_axi_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  output logic [3:0]  rid
);

  state_t state, state_nxt;

  logic [7:0]  lat_cnt, beat_q, len_q, nxt_beat, cur_len;
  logic [31:0] addr_q, rd_addr, mem_data, rdata_q;
  logic [1:0]  burst_q, rresp_q;
  logic [3:0]  rid_q;
  logic        err_q, cur_err, range_err, beat_err, nxt_last;
  logic        ar_hs, r_hs, present, rvalid_q, rlast_q;
  logic [DEPTH_LOG2-1:0] word_idx;

  assign arready = (state == IDLE);
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid_q & rready;

  // Next state, plus the address/beat number of whichever beat would be presented next.
  always_comb begin
    state_nxt = state;
    present   = 1'b0;
    rd_addr   = addr_q;
    nxt_beat  = 8'd0;
    cur_len   = len_q;
    cur_err   = err_q;
    case (state)
      IDLE: begin
        rd_addr = araddr;
        cur_len = arlen;
        cur_err = req_err(arsize, arburst);
        if (ar_hs) begin
          if (LATENCY == 1) begin
            state_nxt = BURST;
            present   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt == 8'd0) begin
          state_nxt = BURST;
          present   = 1'b1;
        end
      end
      BURST: begin
        nxt_beat = beat_q + 8'd1;
        if (burst_q == BURST_INCR) rd_addr = addr_q + 32'd4;
        if (r_hs) begin
          if (rlast_q) state_nxt = IDLE;
          else         present   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef YSYX_23060229_RD_RANGE_ERR_EN
  assign range_err = ((rd_addr - BASE_ADDR) >> (DEPTH_LOG2 + 2)) != 32'd0;
`else
  assign range_err = 1'b0;
`endif

  assign word_idx = DEPTH_LOG2'((rd_addr - BASE_ADDR) >> 2);
  assign beat_err = cur_err | range_err;
  assign nxt_last = (nxt_beat == cur_len);

  ysyx_23060229_rd_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_mem (
    .idx  (word_idx),
    .data (mem_data)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request capture, latency countdown and registered R-channel outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_cnt  <= 8'd0;
      beat_q   <= 8'd0;
      len_q    <= 8'd0;
      addr_q   <= 32'd0;
      burst_q  <= BURST_FIXED;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= RESP_OKAY;
      rid_q    <= 4'd0;
    end else begin
      if (ar_hs) begin
        addr_q  <= araddr;
        len_q   <= arlen;
        burst_q <= arburst;
        err_q   <= req_err(arsize, arburst);
        rid_q   <= arid;
        beat_q  <= 8'd0;
        lat_cnt <= 8'(LATENCY - 1);
      end
      if ((state == WAIT) && (lat_cnt != 8'd0)) lat_cnt <= lat_cnt - 8'd1;
      if ((state == BURST) && r_hs && rlast_q) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
      // Presenting a beat overrides capture so LATENCY==1 lands beat 0 directly.
      if (present) begin
        addr_q   <= rd_addr;
        beat_q   <= nxt_beat;
        rvalid_q <= 1'b1;
        rlast_q  <= nxt_last;
        rdata_q  <= beat_err ? 32'd0 : mem_data;
        rresp_q  <= beat_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rid    = rid_q;

endmodule

// File: tb/tb_ysyx_23060229_axi_rd_slave.sv
// Self-checking bench for ysyx_23060229_axi_rd_slave (default parameters).
module tb_ysyx_23060229_axi_rd_slave;

  localparam int          DL    = 14;
  localparam int          DEPTH = 1 << DL;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] araddr = 32'd0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  arid = 4'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        rlast;
  logic [3:0]  rid;

  int total = 0;
  int bad   = 0;

  ysyx_23060229_axi_rd_slave dut (
    .clock   (clock),
    .reset   (reset),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .arid    (arid),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .rlast   (rlast),
    .rid     (rid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected beat list derived from the burst rules with plain address arithmetic.
  function automatic void model(input logic [31:0] addr, input int len,
                                input logic [2:0] size, input logic [1:0] burst);
    exp_q.delete();
    for (int k = 0; k <= len; k++) begin
      beat_t b;
      logic [31:0] a, off;
      bit err, oor;
      a   = (burst == 2'b00) ? addr : addr + 32'(k) * 32'd4;
      off = a - BASE;
      err = (size != 3'b010) || (burst > 2'b01);
      oor = 1'b0;
`ifdef YSYX_23060229_RD_RANGE_ERR_EN
      oor = (off >= 32'(4 * DEPTH));
`endif
      b.data = (err || oor) ? 32'd0 : 32'h1000_0000 + ((off >> 2) % DEPTH);
      b.resp = (err || oor) ? 2'b10 : 2'b00;
      b.last = (k == len);
      exp_q.push_back(b);
    end
  endfunction

  // One full read transaction. mode: 0 rready high, 1 toggle 1/0, 2 random.
  task automatic run_read(input string tag, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] id, input int mode);
    int lat, cnt, cyc;
    bit stalled;
    logic [38:0] snap;
    model(addr, len, size, burst);
    @(negedge clock);
    chk({tag, "_arready_idle"}, arready, 1);
    araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arid = id;
    arvalid = 1'b1; rready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    arvalid = 1'b0; araddr = $urandom; arlen = 8'($urandom); arid = 4'($urandom);
    chk({tag, "_arready_drop"}, arready, 0);
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(posedge clock); lat++; @(negedge clock);
    end
    chk({tag, "_latency"}, lat, 2);
    cnt = 0; cyc = 0; stalled = 1'b0; snap = '0;
    while (cnt <= len && cyc < 2000) begin
      if (stalled) chk({tag, "_stall_stable"}, {rvalid, rdata, rresp, rlast, rid}, {1'b1, snap});
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 2 == 0);
        default: rready = 1'($urandom);
      endcase
      if (rvalid && rready) begin
        chk($sformatf("%s_beat%0d", tag, cnt), {rdata, rresp, rlast, rid},
            {exp_q[cnt].data, exp_q[cnt].resp, exp_q[cnt].last, id});
        cnt++;
        stalled = 1'b0;
      end else if (rvalid) begin
        snap = {rdata, rresp, rlast, rid};
        stalled = 1'b1;
      end
      @(posedge clock); cyc++; @(negedge clock);
    end
    chk({tag, "_beat_count"}, cnt, len + 1);
    chk({tag, "_end_state"}, {arready, rvalid}, 2'b10);
    rready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] ra;
    for (int i = 0; i < DEPTH; i++) dut.u_mem.mem[i] = 32'h1000_0000 + 32'(i);

    #1;
    chk("reset_outputs", {arready, rvalid, rlast, rresp, rid, rdata}, {1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 32'd0});
    @(negedge clock); reset = 1'b1;

    run_read("incr2",      BASE + 32'h8,  1, 3'b010, 2'b01, 4'd1, 0);
    run_read("incr2_tgl",  BASE + 32'h8,  1, 3'b010, 2'b01, 4'd1, 1);
    run_read("fixed1",     BASE + 32'h10, 0, 3'b010, 2'b00, 4'd2, 0);
    run_read("fixed4",     BASE + 32'h10, 3, 3'b010, 2'b00, 4'd3, 1);
    run_read("size_err",   BASE + 32'h20, 2, 3'b011, 2'b01, 4'd4, 0);
    run_read("burst_err",  BASE + 32'h20, 1, 3'b010, 2'b10, 4'd6, 2);
    run_read("below_base", 32'h7FFF_FFFC, 1, 3'b010, 2'b01, 4'd7, 0);
    run_read("top_wrap",   BASE + 32'(4 * (DEPTH - 2)), 3, 3'b010, 2'b01, 4'd8, 2);
    run_read("unaligned",  BASE + 32'h33,  2, 3'b010, 2'b01, 4'd9, 0);

    // Reset asserted while beat 1 of an 8-beat burst is on the bus.
    @(negedge clock);
    araddr = BASE; arlen = 8'd7; arsize = 3'b010; arburst = 2'b01; arid = 4'd5;
    arvalid = 1'b1; rready = 1'b1;
    @(posedge clock); @(negedge clock);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(posedge clock); lat++; @(negedge clock);
    end
    chk("rst_beat0", rdata, 32'h1000_0000);
    @(posedge clock); @(negedge clock);
    chk("rst_beat1", {rvalid, rdata}, {1'b1, 32'h1000_0001});
    reset = 1'b0;
    #1;
    chk("rst_async", {arready, rvalid, rlast, rid, rdata}, {1'b1, 1'b0, 1'b0, 4'd0, 32'd0});
    @(negedge clock); reset = 1'b1; rready = 1'b0;
    run_read("after_rst", BASE + 32'h40, 1, 3'b010, 2'b01, 4'd3, 0);

    for (int t = 0; t < 8; t++) begin
      ra = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
      run_read($sformatf("rnd%0d", t), ra, $urandom_range(0, 15),
               ($urandom_range(0, 3) == 0) ? 3'b011 : 3'b010,
               2'($urandom_range(0, 3)), 4'($urandom), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
